// File: rtl/fpu_pkg.sv
// Shared constants and stage payload types for the FPU multiply rounding path.
package fpu_pkg;

  localparam int MANT_W = 56;
  localparam int EXP_W  = 12;
  localparam int FRAC_W = 52;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } rmode_e;

  localparam logic [EXP_W-1:0] EXP_INF    = 12'd2047;
  localparam logic [62:0]      MAX_FINITE = 63'h7FEF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic             sign;
    logic [53:0]      mant;     // carry slot, hidden bit, fraction
    logic [EXP_W-1:0] exp;
    logic             roundup;
    logic             inexact;
    logic             zero;
    logic [1:0]       rmode;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [54:0]      sum;
    logic [EXP_W-1:0] exp;
    logic             roundup;
    logic             inexact;
    logic             zero;
    logic [1:0]       rmode;
  } s2_t;

  // Saturated result on overflow: infinity or largest finite, by direction.
  function automatic logic [63:0] ovf_result(input logic [1:0] rm, input logic sign);
    logic [63:0] inf_v;
    logic [63:0] max_v;
    inf_v = {sign, EXP_INF[10:0], {FRAC_W{1'b0}}};
    max_v = {sign, MAX_FINITE};
    case (rm)
      RNE:     ovf_result = inf_v;
      RTZ:     ovf_result = max_v;
      RUP:     ovf_result = sign ? max_v : inf_v;
      default: ovf_result = sign ? inf_v : max_v;
    endcase
  endfunction

endpackage

// File: rtl/fpu_round_decide.sv
// Combinational IEEE-754 round-up decision from mode, sign and the lsb/round/sticky bits.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic [1:0] rmode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       rnd,
  input  logic       sticky,
  output logic       roundup,
  output logic       inexact
);

  always_comb begin
    inexact = rnd | sticky;
    roundup = 1'b0;
    case (rmode)
      RNE:     roundup = rnd & (sticky | lsb);
      RTZ:     roundup = 1'b0;
      RUP:     roundup = !sign & inexact;
      default: roundup = sign & inexact;
    endcase
  end

endmodule

// File: rtl/fpu_mul_round.sv
// Three-stage round/renormalise/pack stage after the double-precision multiplier.
// FPU_MUL_ROUND_DIRECTED_EN enables all four rounding modes; otherwise RNE only.
module fpu_mul_round
  import fpu_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              valid_in,
  input  logic [1:0]        rmode,
  input  logic              sign_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              shift_inexact_in,
  output logic              valid_out,
  output logic [63:0]       result,
  output logic              inexact,
  output logic              overflow,
  output logic              underflow
);

  logic [1:0] mode_eff;
`ifdef FPU_MUL_ROUND_DIRECTED_EN
  assign mode_eff = rmode;
`else
  logic unused_rmode;
  assign unused_rmode = ^rmode;
  assign mode_eff     = RNE;
`endif

  logic [LATENCY:1] vld_pipe;
  s1_t              s1_d, s1_q;
  s2_t              s2_q;
  logic             rup, inx;

  fpu_round_decide u_round_decide (
    .rmode   (mode_eff),
    .sign    (sign_in),
    .lsb     (mant_in[2]),
    .rnd     (mant_in[1]),
    .sticky  (mant_in[0] | shift_inexact_in),
    .roundup (rup),
    .inexact (inx)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = sign_in;
    s1_d.mant    = mant_in[55:2];
    s1_d.exp     = exp_in;
    s1_d.roundup = rup;
    s1_d.inexact = inx;
    s1_d.zero    = (exp_in == '0) && (mant_in[54:0] == '0);
    s1_d.rmode   = mode_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (enable) begin
      s1_q         <= s1_d;
      s2_q.sign    <= s1_q.sign;
      s2_q.sum     <= {1'b0, s1_q.mant} + {54'd0, s1_q.roundup};
      s2_q.exp     <= s1_q.exp;
      s2_q.roundup <= s1_q.roundup;
      s2_q.inexact <= s1_q.inexact;
      s2_q.zero    <= s1_q.zero;
      s2_q.rmode   <= s1_q.rmode;
    end
  end

  // Stage 3: sum[53] is the carry slot directly above the hidden bit sum[52].
  logic              carry, promote, inx_n, ovf_n, unf_n;
  logic [EXP_W:0]    exp_f;
  logic [FRAC_W-1:0] frac;
  logic [63:0]       res_n;

  always_comb begin
    carry   = s2_q.sum[54] | s2_q.sum[53];
    promote = (s2_q.exp == '0) && s2_q.roundup && s2_q.sum[52];
    exp_f   = {1'b0, s2_q.exp};
    frac    = s2_q.sum[51:0];
    if (carry) begin
      exp_f = exp_f + 13'd1;
      frac  = s2_q.sum[52:1];
    end else if (promote) begin
      exp_f = 13'd1;
    end
    ovf_n = exp_f >= {1'b0, EXP_INF};
    res_n = {s2_q.sign, exp_f[10:0], frac};
    inx_n = s2_q.inexact;
    unf_n = 1'b0;
    if (s2_q.zero) begin
      res_n = {s2_q.sign, 63'd0};
      inx_n = 1'b0;
      ovf_n = 1'b0;
    end else if (ovf_n) begin
      res_n = ovf_result(s2_q.rmode, s2_q.sign);
      inx_n = 1'b1;
    end else begin
      unf_n = (exp_f == '0) && inx_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      result    <= '0;
      inexact   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (enable) begin
      vld_pipe  <= {vld_pipe[LATENCY-1:1], valid_in};
      result    <= res_n;
      inexact   <= vld_pipe[LATENCY-1] & inx_n;
      overflow  <= vld_pipe[LATENCY-1] & ovf_n;
      underflow <= vld_pipe[LATENCY-1] & unf_n;
    end
  end

  assign valid_out = vld_pipe[LATENCY];

endmodule

// File: tb/tb_fpu_mul_round.sv
// Randomised and directed self-checking bench for fpu_mul_round against an arithmetic model.
module tb_fpu_mul_round;

`ifdef FPU_MUL_ROUND_DIRECTED_EN
  localparam bit DIR = 1'b1;
`else
  localparam bit DIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  rmode = 2'b00;
  logic        sign_in = 1'b0;
  logic [55:0] mant_in = '0;
  logic [11:0] exp_in = '0;
  logic        shift_inexact_in = 1'b0;
  logic        valid_out;
  logic [63:0] result;
  logic        inexact, overflow, underflow;

  fpu_mul_round #(.LATENCY(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in), .rmode(rmode),
    .sign_in(sign_in), .mant_in(mant_in), .exp_in(exp_in),
    .shift_inexact_in(shift_inexact_in), .valid_out(valid_out), .result(result),
    .inexact(inexact), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        inx, ovf, unf;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  bit   last_v;
  int   ecnt, n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input bit x, input bit o, input bit u);
    exp_t e;
    e.res = r; e.inx = x; e.ovf = o; e.unf = u; e.due = 0;
    return e;
  endfunction

  // Reference: IEEE rounding on the 54-bit significand as an integer.
  function automatic exp_t model(input logic [1:0] rm, input bit s, input logic [55:0] m,
                                 input logic [11:0] e, input bit si);
    exp_t              r;
    logic [1:0]        md;
    bit                st, rb, lb, up, ix;
    longint unsigned   sig, frac;
    int                ef;
    md = DIR ? rm : 2'b00;
    st = m[0] | si; rb = m[1]; lb = m[2];
    ix = rb | st;
    case (md)
      2'b00: up = rb & (st | lb);
      2'b01: up = 1'b0;
      2'b10: up = !s & ix;
      default: up = s & ix;
    endcase
    if (e == 0 && m[54:0] == 0) return mk({s, 63'd0}, 0, 0, 0);
    sig = longint'(m[55:2]) + longint'(up);
    ef  = int'(e);
    if (sig >= 64'h0020_0000_0000_0000) begin
      frac = (sig >> 1) & 64'h000F_FFFF_FFFF_FFFF;
      ef   = ef + 1;
    end else begin
      frac = sig & 64'h000F_FFFF_FFFF_FFFF;
      if (ef == 0 && up && sig >= 64'h0010_0000_0000_0000) ef = 1;
    end
    if (ef >= 2047) begin
      logic [63:0] inf_v, max_v;
      inf_v = {s, 63'h7FF0_0000_0000_0000};
      max_v = {s, 63'h7FEF_FFFF_FFFF_FFFF};
      case (md)
        2'b00: r.res = inf_v;
        2'b01: r.res = max_v;
        2'b10: r.res = s ? max_v : inf_v;
        default: r.res = s ? inf_v : max_v;
      endcase
      r.inx = 1; r.ovf = 1; r.unf = 0;
    end else begin
      r.res = {s, ef[10:0], frac[51:0]};
      r.inx = ix; r.ovf = 0; r.unf = (ef == 0) && ix;
    end
    r.due = 0;
    return r;
  endfunction

  task automatic observe(input bit en);
    exp_t x;
    if (!en) begin
      chk("hold_valid", valid_out, last_v);
      if (last_v) chk("hold_result", result, last_e.res);
      return;
    end
    last_v = 1'b0;
    if (valid_out) begin
      if (q.size() == 0) chk("spurious_valid", valid_out, 0);
      else begin
        x = q.pop_front();
        chk("latency", ecnt, x.due);
        chk("result", result, x.res);
        chk("flags", {inexact, overflow, underflow}, {x.inx, x.ovf, x.unf});
        last_e = x; last_v = 1'b1;
      end
    end else begin
      chk("flags_idle", {inexact, overflow, underflow}, 0);
      if (q.size() > 0 && q[0].due <= ecnt) begin
        chk("missing_valid", valid_out, 1);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic issue(input bit en, input bit v, input logic [1:0] rm, input bit s,
                       input logic [55:0] m, input logic [11:0] e, input bit si, input exp_t ex);
    exp_t x;
    enable = en; valid_in = v; rmode = rm; sign_in = s;
    mant_in = m; exp_in = e; shift_inexact_in = si;
    @(posedge clk);
    if (en) begin
      if (v) begin x = ex; x.due = ecnt + 3; q.push_back(x); end
      ecnt++;
    end
    #1 observe(en);
  endtask

  task automatic idle(input bit en);
    issue(en, 0, 2'b00, 0, '0, '0, 0, mk('0, 0, 0, 0));
  endtask

  localparam logic [55:0] ONE   = 56'h40_0000_0000_0000;
  localparam logic [55:0] ONES  = 56'h7F_FFFF_FFFF_FFFE;
  localparam logic [55:0] DENRM = 56'h3F_FFFF_FFFF_FFFE;

  initial begin
    logic [63:0] r64;
    logic [55:0] m;
    logic [11:0] e;
    bit          en, v, s, si;
    logic [1:0]  rm;
    ecnt = 0; n_chk = 0; n_fail = 0; last_v = 0; last_e = mk('0, 0, 0, 0);

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {inexact, overflow, underflow}, 0);
    rst = 1'b0;

    // Directed cases
    issue(1, 1, 2'b00, 0, ONE, 12'd1023, 0, mk(64'h3FF0_0000_0000_0000, 0, 0, 0));
    issue(1, 1, 2'b00, 0, ONE | 56'd2, 12'd1023, 0, mk(64'h3FF0_0000_0000_0000, 1, 0, 0));
    issue(1, 1, 2'b00, 0, ONE | 56'd6, 12'd1023, 0, mk(64'h3FF0_0000_0000_0002, 1, 0, 0));
    issue(1, 1, 2'b00, 0, ONES, 12'd1023, 0, mk(64'h4000_0000_0000_0000, 1, 0, 0));
    issue(1, 1, 2'b01, 0, ONE, 12'd2047, 0,
          mk(DIR ? 64'h7FEF_FFFF_FFFF_FFFF : 64'h7FF0_0000_0000_0000, 1, 1, 0));
    issue(1, 1, 2'b00, 0, ONE, 12'd2047, 0, mk(64'h7FF0_0000_0000_0000, 1, 1, 0));
    issue(1, 1, 2'b10, 0, DENRM, 12'd0, 0, mk(64'h0010_0000_0000_0000, 1, 0, 0));
    issue(1, 1, 2'b01, 0, DENRM, 12'd0, 0,
          DIR ? mk(64'h000F_FFFF_FFFF_FFFF, 1, 0, 1) : mk(64'h0010_0000_0000_0000, 1, 0, 0));
    issue(1, 1, 2'b11, 1, '0, 12'd0, 0, mk(64'h8000_0000_0000_0000, 0, 0, 0));
    issue(1, 1, 2'b11, 1, ONE, 12'd2047, 0,
          mk(64'hFFF0_0000_0000_0000, 1, 1, 0));
    repeat (4) idle(1);

    // Back-to-back with an enable stall; stalled valid_in must be ignored
    issue(1, 1, 2'b00, 0, ONE, 12'd1023, 0, mk(64'h3FF0_0000_0000_0000, 0, 0, 0));
    issue(1, 1, 2'b00, 1, ONE | 56'd6, 12'd1023, 0, mk(64'hBFF0_0000_0000_0002, 1, 0, 0));
    issue(1, 1, 2'b00, 0, ONES, 12'd1023, 0, mk(64'h4000_0000_0000_0000, 1, 0, 0));
    issue(0, 1, 2'b00, 0, ONE, 12'd5, 0, mk('0, 0, 0, 0));
    issue(0, 1, 2'b00, 0, ONE, 12'd6, 0, mk('0, 0, 0, 0));
    repeat (5) idle(1);

    // Asynchronous reset with two operands in flight
    issue(1, 1, 2'b00, 0, ONE, 12'd1023, 0, mk(64'h3FF0_0000_0000_0000, 0, 0, 0));
    issue(1, 1, 2'b00, 0, ONE, 12'd1000, 0, mk(64'h3E80_0000_0000_0000, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    chk("rst_inflight_valid", valid_out, 0);
    chk("rst_inflight_flags", {inexact, overflow, underflow}, 0);
    q.delete(); last_v = 0;
    @(negedge clk) rst = 1'b0;
    repeat (5) idle(1);

    // Random stream with random enable gaps and mode changes
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      v  = $urandom_range(0, 3) != 0;
      rm = 2'($urandom_range(0, 3));
      s  = 1'($urandom);
      si = ($urandom_range(0, 7) == 0);
      r64 = {$urandom(), $urandom()};
      m = r64[55:0];
      case ($urandom_range(0, 5))
        0: e = 12'd0;
        1: e = 12'($urandom_range(1, 2046));
        2: e = 12'd2046;
        3: e = 12'($urandom_range(2047, 2100));
        4: e = 12'd1023;
        default: e = 12'($urandom_range(1, 10));
      endcase
      m[55] = 1'b0;
      m[54] = (e != 0);
      if ($urandom_range(0, 3) == 0) m[53:2] = '1;
      if (e == 0 && $urandom_range(0, 7) == 0) begin m = '0; si = 0; end
      issue(en, v, rm, s, m, e, si, model(rm, s, m, e, si));
    end
    repeat (5) idle(1);
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
